// File: rtl/debug_frame_pkg.sv
// Shared encodings and sizing helpers for the debug snapshot serialiser
// (debug_frame_tx and its byte shifter).
package debug_frame_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        PH_HDR  = 2'd0,
        PH_LEN  = 2'd1,
        PH_DATA = 2'd2,
        PH_CKS  = 2'd3
    } phase_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // The LEN byte is a single UART byte, so a frame carries at most 255 data bytes.
    localparam int MAX_N_BYTES = 255;

    function automatic int n_bytes_of(input int nb_payload);
        return (nb_payload + 7) / 8;
    endfunction

endpackage

// File: rtl/debug_frame_if.sv
// Byte-level start/done handshake between the frame serialiser and uart_tx.
// Signal directions are named from the serialiser's point of view.
interface debug_frame_if;

    logic       o_tx_start;
    logic [7:0] o_data;
    logic       i_txDone;

    modport master (
        output o_tx_start,
        output o_data,
        input  i_txDone
    );

    modport slave (
        input  o_tx_start,
        input  o_data,
        output i_txDone
    );

endinterface

// File: rtl/debug_byte_shifter.sv
// Parallel-load snapshot register that presents the payload MSB-first one byte
// at a time, with a data-byte counter and last-byte flag.
module debug_byte_shifter
    import debug_frame_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int NB_PAYLOAD = 280,
    parameter int N_BYTES    = n_bytes_of(NB_PAYLOAD)
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [NB_PAYLOAD-1:0] i_payload,
    input  logic                  i_shift,
    output logic [NB_DATA-1:0]    o_byte,
    output logic                  o_last
);

    localparam int NB_SREG = N_BYTES * NB_DATA;

    logic [NB_SREG-1:0] r_sreg;
    logic [7:0]         r_cnt;
    logic [NB_SREG-1:0] w_padded;

    // Right-align the payload; the cast zero-fills the unused upper bits.
    assign w_padded = NB_SREG'(i_payload);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sreg <= w_padded;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_sreg <= r_sreg << NB_DATA;
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    assign o_byte = r_sreg[NB_SREG-1 -: NB_DATA];
    assign o_last = (r_cnt == 8'(N_BYTES - 1));

endmodule

// File: rtl/debug_frame_tx.sv
// Debug snapshot serialiser: HEADER, LEN, payload bytes MSB-first and, when
// DEBUG_FRAME_CKSUM_EN is defined, a trailing XOR checksum byte.
module debug_frame_tx
    import debug_frame_pkg::*;
#(
    parameter int         NB_DATA    = 8,
    parameter int         NB_PAYLOAD = 280,
    parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [NB_PAYLOAD-1:0] i_payload,
    input  logic                  i_capture,
    input  logic                  i_mode_cont,
    input  logic                  i_clr_overrun,
    debug_frame_if.master         uart,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overrun
);

    localparam int                 N_BYTES  = n_bytes_of(NB_PAYLOAD);
    localparam logic [NB_DATA-1:0] LEN_BYTE = NB_DATA'(N_BYTES);

    logic [1:0]         r_state;
    phase_e             r_phase;
    logic               r_overrun;
    logic               w_load;
    logic               w_byte_done;
    logic               w_shift;
    logic               w_last;
    logic [NB_DATA-1:0] w_shift_byte;
    logic [NB_DATA-1:0] w_cur_byte;

    assign w_load      = (r_state == ST_IDLE) && (i_capture || i_mode_cont);
    assign w_byte_done = (r_state == ST_WAIT) && uart.i_txDone;
    assign w_shift     = w_byte_done && (r_phase == PH_DATA) && !w_last;

    debug_byte_shifter #(
        .NB_DATA    (NB_DATA),
        .NB_PAYLOAD (NB_PAYLOAD),
        .N_BYTES    (N_BYTES)
    ) u_shifter (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load),
        .i_payload (i_payload),
        .i_shift   (w_shift),
        .o_byte    (w_shift_byte),
        .o_last    (w_last)
    );

`ifdef DEBUG_FRAME_CKSUM_EN
    logic [NB_DATA-1:0] r_cks;

    // Seeding with the LEN value folds the LEN byte into the checksum for free.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cks <= '0;
        end else if (w_load) begin
            r_cks <= LEN_BYTE;
        end else if (w_byte_done && (r_phase == PH_DATA)) begin
            r_cks <= r_cks ^ w_shift_byte;
        end
    end
`endif

    always_comb begin
        w_cur_byte = '0;
        case (r_phase)
            PH_HDR:  w_cur_byte = HEADER;
            PH_LEN:  w_cur_byte = LEN_BYTE;
            PH_DATA: w_cur_byte = w_shift_byte;
            default: begin
`ifdef DEBUG_FRAME_CKSUM_EN
                w_cur_byte = r_cks;
`else
                w_cur_byte = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= PH_HDR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_START;
                        r_phase <= PH_HDR;
                    end
                end
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (uart.i_txDone) begin
                        case (r_phase)
                            PH_HDR: begin
                                r_phase <= PH_LEN;
                                r_state <= ST_START;
                            end
                            PH_LEN: begin
                                r_phase <= PH_DATA;
                                r_state <= ST_START;
                            end
                            PH_DATA: begin
                                if (!w_last) begin
                                    r_state <= ST_START;
                                end else begin
`ifdef DEBUG_FRAME_CKSUM_EN
                                    r_phase <= PH_CKS;
                                    r_state <= ST_START;
`else
                                    r_state <= ST_DONE;
`endif
                                end
                            end
                            default: r_state <= ST_DONE;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A capture request while busy is only recorded; setting beats clearing.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (i_capture && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign uart.o_tx_start = (r_state == ST_START);
    assign uart.o_data     = ((r_state == ST_START) || (r_state == ST_WAIT)) ? w_cur_byte : '0;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_frame_done    = (r_state == ST_DONE);
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Scoreboard bench for debug_frame_tx with a 20-bit payload and a behavioural
// uart_tx responder.
`timescale 1ns/1ps
module tb_debug_frame_tx;

    localparam int NB   = 20;
    localparam int NBY  = (NB + 7) / 8;
    localparam int MARK = 256;
`ifdef DEBUG_FRAME_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] payload = '0;
    logic          capture = 1'b0;
    logic          mode_cont = 1'b0;
    logic          clr = 1'b0;
    logic          busy, frame_done, overrun;
    logic          resp_done = 1'b0;
    logic          idle_done = 1'b0;
    logic          resp_rand = 1'b0;
    logic          spur_start = 1'b0;

    debug_frame_if uart_if();
    assign uart_if.i_txDone = resp_done | idle_done;

    debug_frame_tx #(
        .NB_DATA    (8),
        .NB_PAYLOAD (NB),
        .HEADER     (8'hA5)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_payload     (payload),
        .i_capture     (capture),
        .i_mode_cont   (mode_cont),
        .i_clr_overrun (clr),
        .uart          (uart_if),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int n_starts = 0;
    int n_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, byte count, payload as base-256 digits high first,
    // optional XOR of count and digits, then an end-of-frame marker.
    task automatic push_frame(input logic [NB-1:0] p);
        int pv;
        int b;
        int cks;
        pv  = int'(p);
        cks = NBY;
        exp_q.push_back(8'hA5);
        exp_q.push_back(NBY);
        for (int i = NBY - 1; i >= 0; i--) begin
            b   = (pv >> (8 * i)) & 255;
            cks = cks ^ b;
            exp_q.push_back(b);
        end
        if (CK == 1) exp_q.push_back(cks);
        exp_q.push_back(MARK);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a byte or ends a frame.
    always @(negedge clk) begin
        if (uart_if.o_tx_start) begin
            n_starts++;
            check("sb_has_byte", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("o_data", int'(uart_if.o_data), exp_q.pop_front());
        end
        if (frame_done) begin
            n_done++;
            if (exp_q.size() != 0) check("frame_end_pos", exp_q.pop_front(), MARK);
            else check("frame_end_pos", -1, MARK);
        end
    end

    // uart_tx stand-in: answers each start with a one-cycle done pulse.
    initial begin
        int d;
        @(negedge clk);
        forever begin
            if (uart_if.o_tx_start) begin
                d = resp_rand ? int'($urandom_range(1, 12)) : 10;
                if (spur_start) begin
                    resp_done = 1'b1;
                    @(negedge clk);
                    resp_done = 1'b0;
                end
                repeat (d) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic wait_starts(input int target, input string name);
        int budget = 2000;
        while (n_starts < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check(name, n_starts, target);
    endtask

    task automatic wait_done(input int target, input string name);
        int budget = 2000;
        while (n_done < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check(name, n_done, target);
        @(negedge clk);
    endtask

    task automatic wait_fd(input string name);
        int budget = 2000;
        do begin
            @(negedge clk);
            budget--;
        end while (!frame_done && budget > 0);
        if (budget == 0) check(name, int'(frame_done), 1);
    endtask

    task automatic pulse_capture(input logic [NB-1:0] p);
        payload = p;
        push_frame(p);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, int'(uart_if.o_tx_start), 0);
        check({tag, "_data"}, int'(uart_if.o_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        int gap;
        logic [NB-1:0] p;

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame and first-start latency
        s0 = n_starts;
        d0 = n_done;
        pulse_capture(20'hABCDE);
        check("t1_latency", int'(uart_if.o_tx_start), 1);
        wait_done(d0 + 1, "t1_timeout");
        check("t1_starts", n_starts - s0, NBY + 2 + CK);
        check("t1_done_cnt", n_done - d0, 1);
        check("t1_busy_after", int'(busy), 0);

        // Payload change after capture
        s0 = n_starts;
        pulse_capture(20'hABCDE);
        wait_starts(s0 + 2, "t2_timeout");
        payload = 20'h12345;
        wait_done(n_done + 1, "t2_done_timeout");

        // Overrun set, set-beats-clear, clear while idle
        s0 = n_starts;
        pulse_capture(20'h5A5A5);
        wait_starts(s0 + 3, "t3_timeout");
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        check("t3_overrun_set", int'(overrun), 1);
        capture = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        clr = 1'b0;
        check("t3_set_wins", int'(overrun), 1);
        wait_done(n_done + 1, "t3_done_timeout");
        check("t3_idle", int'(busy), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_cleared", int'(overrun), 0);

        // Continuous mode with 2-cycle inter-frame gap
        payload = 20'h00001;
        push_frame(20'h00001);
        mode_cont = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_fd("t4_fd_timeout");
            push_frame(20'h00001);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!uart_if.o_tx_start && gap < 10);
            check("t4_gap", gap, 2);
        end
        wait_starts(n_starts + 2, "t4_timeout");
        mode_cont = 1'b0;
        wait_fd("t4_last_timeout");
        s0 = n_starts;
        repeat (30) @(negedge clk);
        check("t4_stopped", n_starts - s0, 0);

        // Asynchronous reset during the second data byte
        s0 = n_starts;
        pulse_capture(20'(int'($urandom_range(0, 32'hFFFFF))));
        wait_starts(s0 + 4, "t5_timeout");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_starts;
        repeat (20) @(negedge clk);
        check("t5_no_start", n_starts - s0, 0);
        s0 = n_starts;
        pulse_capture(20'(int'($urandom_range(0, 32'hFFFFF))));
        wait_done(n_done + 1, "t5_done_timeout");
        check("t5_starts", n_starts - s0, NBY + 2 + CK);

        // Spurious done pulses in IDLE and START, then randomised frames
        s0 = n_starts;
        for (int k = 0; k < 3; k++) begin
            idle_done = 1'b1;
            @(negedge clk);
            idle_done = 1'b0;
            @(negedge clk);
        end
        check("t6_idle_busy", int'(busy), 0);
        check("t6_idle_starts", n_starts - s0, 0);
        resp_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            spur_start = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            s0 = n_starts;
            p = 20'(int'($urandom_range(0, 32'hFFFFF)));
            pulse_capture(p);
            wait_done(n_done + 1, "t6_done_timeout");
            check("t6_starts", n_starts - s0, NBY + 2 + CK);
        end
        spur_start = 1'b0;
        resp_rand = 1'b0;

        repeat (5) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
